// File: rtl/p_addsub_mc.sv
// Multi-cycle packed adder/subtractor: CW bits per cycle with a registered carry
// crossing chunk boundaries inside a lane, followed by an optional unsigned saturation pass.
module p_addsub_mc #(
  parameter int XLEN = 64,
  parameter int CW   = 16,
  parameter int PWN  = $clog2(XLEN)
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [PWN-1:0]  pw,
  input  logic            sub,
  input  logic            cin,
  input  logic            sat,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] c_out,
  output logic            pw_err
);

  localparam int NC = XLEN / CW;
  localparam int KW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NC - 1);

  typedef enum logic [1:0] {IDLE, RUN, SAT, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] lhs_q, rhs_q;
  logic [PWN-1:0]  pw_q;
  logic            sub_q, cin_q, sat_q;
  logic [KW-1:0]   k_q;
  logic            carry_q;
  logic [XLEN-1:0] result_q, c_out_q;
  logic            pw_err_q;

  logic [XLEN-1:0] lsb_mask, msb_mask, lane_co, sat_result;
  logic [CW-1:0]   sum_chunk, cout_chunk;
  logic            carry_d;
  logic            pw_valid;
  int              chunk_base;

  // Lane LSB/MSB positions for the held width; an invalid pw ORs several widths together
  always_comb begin
    lsb_mask = '0;
    msb_mask = '0;
    for (int i = 0; i < XLEN; i++) begin
      for (int j = 0; j < PWN; j++) begin
        if (pw_q[j] && ((i & ((XLEN >> j) - 1)) == 0))
          lsb_mask[i] = 1'b1;
        if (pw_q[j] && (((i + 1) & ((XLEN >> j) - 1)) == 0))
          msb_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic          carry;
    logic          lane_cin;
    logic [CW-1:0] a_c, b_c, lsb_c, msb_c;
    chunk_base = int'(k_q) * CW;
    a_c        = lhs_q[chunk_base +: CW];
    b_c        = rhs_q[chunk_base +: CW];
    lsb_c      = lsb_mask[chunk_base +: CW];
    msb_c      = msb_mask[chunk_base +: CW];
    lane_cin   = sub_q | cin_q;
    carry      = carry_q;
    sum_chunk  = '0;
    cout_chunk = '0;
    for (int b = 0; b < CW; b++) begin
      if (lsb_c[b])
        carry = lane_cin;
      sum_chunk[b]  = a_c[b] ^ b_c[b] ^ carry;
      carry         = (a_c[b] & b_c[b]) | (carry & (a_c[b] ^ b_c[b]));
      cout_chunk[b] = msb_c[b] & carry;
    end
    carry_d = carry;
  end

  // Spread each lane's carry-out across the whole lane for the saturation pass
  always_comb begin
    lane_co = '0;
    for (int i = 0; i < XLEN; i++)
      for (int j = 0; j < PWN; j++)
        if (pw_q[j])
          lane_co[i] = lane_co[i] | c_out_q[i | ((XLEN >> j) - 1)];
    pw_valid = (pw_q != '0) && ((pw_q & (pw_q - 1'b1)) == '0);
    if (!pw_valid)
      sat_result = '0;
    else if (!sat_q)
      sat_result = result_q;
    else if (sub_q)
      sat_result = result_q & lane_co;
    else
      sat_result = result_q | lane_co;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (k_q == K_LAST) state_d = SAT;
      SAT:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q  <= IDLE;
      lhs_q    <= '0;
      rhs_q    <= '0;
      pw_q     <= '0;
      sub_q    <= 1'b0;
      cin_q    <= 1'b0;
      sat_q    <= 1'b0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= '0;
      pw_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            lhs_q    <= lhs;
            rhs_q    <= sub ? ~rhs : rhs;
            pw_q     <= pw;
            sub_q    <= sub;
            cin_q    <= cin;
            sat_q    <= sat;
            k_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            c_out_q  <= '0;
            pw_err_q <= 1'b0;
          end
        end
        RUN: begin
          result_q[chunk_base +: CW] <= sum_chunk;
          c_out_q[chunk_base +: CW]  <= cout_chunk;
          carry_q                    <= carry_d;
          if (k_q != K_LAST)
            k_q <= k_q + 1'b1;
        end
        SAT: begin
          result_q <= sat_result;
          if (!pw_valid)
            c_out_q <= '0;
          pw_err_q <= ~pw_valid;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && g_resetn;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign pw_err    = pw_err_q;

endmodule

// File: tb/tb_p_addsub_mc.sv
// Scoreboard bench for p_addsub_mc: expected lane results come from a per-lane
// integer-arithmetic model and are matched against each DUT output handshake.
module tb_p_addsub_mc;

  localparam int XLEN = 64;
  localparam int CW   = 16;
  localparam int PWN  = 6;
  localparam int NC   = XLEN / CW;

  typedef struct packed {
    logic [63:0] result;
    logic [63:0] c_out;
    logic        pw_err;
  } exp_t;

  logic            g_clk = 1'b0;
  logic            g_resetn;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] lhs, rhs;
  logic [PWN-1:0]  pw;
  logic            sub, cin, sat;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result, c_out;
  logic            pw_err;

  logic rand_bp = 1'b0;
  logic rnd_ready = 1'b1;
  logic dir_ready = 1'b1;
  assign out_ready = rand_bp ? rnd_ready : dir_ready;

  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  p_addsub_mc #(.XLEN(XLEN), .CW(CW), .PWN(PWN)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .in_valid(in_valid), .in_ready(in_ready),
    .lhs(lhs), .rhs(rhs), .pw(pw), .sub(sub), .cin(cin), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .c_out(c_out),
    .pw_err(pw_err)
  );

  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) begin
    cyc <= cyc + 1;
    rnd_ready <= ($urandom_range(0, 2) != 0);
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Per-lane reference: subtraction is a + (2^lw - 1 - b) + 1, carry is bit lw of the sum
  function automatic exp_t ref_model(input logic [63:0] l, input logic [63:0] r,
                                     input logic [5:0] p, input logic s, input logic c,
                                     input logic sa);
    exp_t e;
    int lw;
    logic [64:0] a, b, sum, ones;
    logic co;
    e = '0;
    if ($countones(p) != 1) begin
      e.pw_err = 1'b1;
      return e;
    end
    lw = 0;
    for (int j = 0; j < 6; j++) if (p[j]) lw = 64 >> j;
    ones = (65'd1 << lw) - 65'd1;
    for (int base = 0; base < 64; base += lw) begin
      a = '0;
      b = '0;
      for (int t = 0; t < lw; t++) begin
        a[t] = l[base + t];
        b[t] = r[base + t];
      end
      if (s) sum = a + (ones - b) + 65'd1;
      else   sum = a + b + {64'd0, c};
      co = sum[lw];
      if (sa && !s && co) sum = ones;
      if (sa && s && !co) sum = '0;
      for (int t = 0; t < lw; t++) e.result[base + t] = sum[t];
      e.c_out[base + lw - 1] = co;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard at every output handshake and checks first-valid latency
  always @(negedge g_clk) begin
    exp_t e;
    if (g_resetn) begin
      if (out_valid && !prev_valid)
        check_output("latency", 64'(cyc - accept_cyc), 64'(NC + 1));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_output("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_output("result", result, e.result);
          check_output("c_out", c_out, e.c_out);
          check_output("pw_err", {63'd0, pw_err}, {63'd0, e.pw_err});
        end
      end
    end
    prev_valid = out_valid && g_resetn;
  end

  task automatic apply_stimulus(input logic [63:0] l, input logic [63:0] r, input logic [5:0] p,
                                input logic s, input logic c, input logic sa);
    int waited;
    waited = 0;
    @(negedge g_clk);
    while (!in_ready && waited < 200) begin
      @(negedge g_clk);
      waited++;
    end
    if (!in_ready) begin
      check_output("accept_timeout", 64'd0, 64'd1);
      return;
    end
    lhs = l; rhs = r; pw = p; sub = s; cin = c; sat = sa;
    in_valid = 1'b1;
    sb.push_back(ref_model(l, r, p, s, c, sa));
    @(posedge g_clk);
    #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    lhs = {$urandom, $urandom};
    rhs = {$urandom, $urandom};
    pw = 6'($urandom);
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || !in_ready) && waited < 400) begin
      @(negedge g_clk);
      waited++;
    end
    if (sb.size() != 0 || !in_ready) check_output("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    exp_t e;
    logic [5:0] rp;
    int waited;
    g_resetn = 1'b0; in_valid = 1'b1;
    lhs = '0; rhs = '0; pw = 6'b000010; sub = 1'b0; cin = 1'b0; sat = 1'b0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    check_output("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_output("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_result", result, 64'd0);
    check_output("rst_c_out", c_out, 64'd0);
    check_output("rst_pw_err", {63'd0, pw_err}, 64'd0);
    in_valid = 1'b0;
    g_resetn = 1'b1;
    @(negedge g_clk);
    check_output("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    $display("[TB] directed vectors");
    apply_stimulus(64'h00000001_FFFFFFFF, 64'h00000001_00000001, 6'b000010, 1'b0, 1'b0, 1'b0);
    wait_idle();
    apply_stimulus(64'h0000FFFF_FFFFFFFF, 64'd1, 6'b000001, 1'b0, 1'b0, 1'b0);
    apply_stimulus(64'd0, 64'h01010101_01010101, 6'b001000, 1'b1, 1'b0, 1'b0);
    apply_stimulus(64'd0, 64'h01010101_01010101, 6'b001000, 1'b1, 1'b0, 1'b1);
    apply_stimulus(64'hFFFFFFFF_FFFFFFFF, 64'h00010001_00010001, 6'b000100, 1'b0, 1'b0, 1'b1);
    apply_stimulus(64'hFFFFFFFF_FFFFFFFF, 64'h00010001_00010001, 6'b000100, 1'b0, 1'b0, 1'b0);
    apply_stimulus(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 6'b000011, 1'b0, 1'b0, 1'b0);
    apply_stimulus(64'hA5A5A5A5_5A5A5A5A, 64'h33333333_CCCCCCCC, 6'b100000, 1'b0, 1'b1, 1'b0);
    wait_idle();

    $display("[TB] backpressure");
    @(posedge g_clk); #1;
    dir_ready = 1'b0;
    e = ref_model(64'hFFFF0000_0000FFFF, 64'h00010000_00000001, 6'b000010, 1'b0, 1'b0, 1'b0);
    apply_stimulus(64'hFFFF0000_0000FFFF, 64'h00010000_00000001, 6'b000010, 1'b0, 1'b0, 1'b0);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge g_clk);
      waited++;
    end
    check_output("bp_reach_done", {63'd0, out_valid}, 64'd1);
    lhs = 64'd7; rhs = 64'd9; in_valid = 1'b1;
    repeat (3) begin
      @(negedge g_clk);
      check_output("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check_output("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check_output("bp_result", result, e.result);
    end
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    dir_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    check_output("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    check_output("bp_release_out_valid", {63'd0, out_valid}, 64'd0);

    $display("[TB] reset mid-run");
    apply_stimulus(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 6'b000100, 1'b0, 1'b0, 1'b0);
    @(posedge g_clk);
    @(posedge g_clk); #1;
    g_resetn = 1'b0;
    @(posedge g_clk);
    @(negedge g_clk);
    check_output("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("mid_rst_result", result, 64'd0);
    check_output("mid_rst_c_out", c_out, 64'd0);
    check_output("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    sb.delete();
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(negedge g_clk);
    check_output("mid_rst_release_in_ready", {63'd0, in_ready}, 64'd1);

    $display("[TB] pw error");
    apply_stimulus(64'hFFFF_FFFF_0000_0001, 64'h0000_0001_0000_0001, 6'b000011, 1'b0, 1'b0, 1'b1);
    apply_stimulus(64'h1234, 64'h5678, 6'b000000, 1'b1, 1'b0, 1'b0);
    wait_idle();

    $display("[TB] random traffic");
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rp = ($urandom_range(0, 4) != 0) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom);
      apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, rp,
                     1'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle();
    rand_bp = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
